datapath_ctrl: RTL and testbench

Instruction sequencer for the 8×16 register-file datapath. Accepts one 16-bit instruction per start handshake, decodes it, and steps the datapath's control lines through read, ALU and write-back cycles. Drives the register file's readnum, writenum and write, plus the A/B/C/status load enables and the operand/ALU selects. The register file's read is combinational, and its write commits on the rising clk edge while write=1.

---
 rtl/datapath_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_datapath_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath_ctrl.sv
// Instruction sequencer for the 8x16 register-file datapath: latches one instruction per start
// and steps the read/ALU/write-back controls. DATAPATH_CTRL_ILLEGAL_TRAP_EN adds a sticky HALT trap.
module datapath_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        s,
  input  logic [15:0] instr,
  output logic        w,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  vsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5,
  output logic        illegal
);

  typedef enum logic [3:0] {
    WAIT   = 4'd0,
    DECODE = 4'd1,
    WIMM   = 4'd2,
    GETA   = 4'd3,
    GETB   = 4'd4,
    ALU    = 4'd5,
    WRC    = 4'd6,
    STAT   = 4'd7
`ifdef DATAPATH_CTRL_ILLEGAL_TRAP_EN
    , HALT = 4'd8
`endif
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] ir;
  logic        write_q;
  logic        loada_q;
  logic        loadb_q;
  logic        loadc_q;
  logic        loads_q;

  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] rn;
  logic [2:0] rd;
  logic [1:0] sh;
  logic [2:0] rm;
  logic       is_mov_imm;
  logic       is_mov_reg;
  logic       is_mvn;
  logic       is_add;
  logic       is_and;
  logic       is_cmp;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];

  assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
  assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
  assign is_mvn     = (opcode == 3'b101) && (op == 2'b11);
  assign is_add     = (opcode == 3'b101) && (op == 2'b00);
  assign is_and     = (opcode == 3'b101) && (op == 2'b10);
  assign is_cmp     = (opcode == 3'b101) && (op == 2'b01);

  assign sximm8 = {{8{ir[7]}}, ir[7:0]};
  assign sximm5 = {{11{ir[4]}}, ir[4:0]};

  // Strobes are cut by reset combinationally so nothing commits on the reset edge.
  assign write = write_q & ~reset;
  assign loada = loada_q & ~reset;
  assign loadb = loadb_q & ~reset;
  assign loadc = loadc_q & ~reset;
  assign loads = loads_q & ~reset;

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT:   state_nxt = s ? DECODE : WAIT;
      DECODE: begin
        if (is_mov_imm)                    state_nxt = WIMM;
        else if (is_mov_reg || is_mvn)     state_nxt = GETB;
        else if (is_add || is_and || is_cmp) state_nxt = GETA;
        else begin
`ifdef DATAPATH_CTRL_ILLEGAL_TRAP_EN
          state_nxt = HALT;
`else
          state_nxt = WAIT;
`endif
        end
      end
      WIMM:   state_nxt = WAIT;
      GETA:   state_nxt = GETB;
      GETB:   state_nxt = is_cmp ? STAT : ALU;
      ALU:    state_nxt = WRC;
      WRC:    state_nxt = WAIT;
      STAT:   state_nxt = WAIT;
`ifdef DATAPATH_CTRL_ILLEGAL_TRAP_EN
      HALT:   state_nxt = HALT;
`endif
      default: state_nxt = WAIT;
    endcase
  end

  // Outputs are registered from the next state so they are valid for the whole state cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= WAIT;
      ir       <= 16'h0000;
      w        <= 1'b1;
      readnum  <= 3'd0;
      writenum <= 3'd0;
      write_q  <= 1'b0;
      loada_q  <= 1'b0;
      loadb_q  <= 1'b0;
      loadc_q  <= 1'b0;
      loads_q  <= 1'b0;
      asel     <= 1'b0;
      bsel     <= 1'b0;
      vsel     <= 2'b00;
      shift    <= 2'b00;
      ALUop    <= 2'b00;
    end else begin
      if (state == WAIT && s) ir <= instr;
      state    <= state_nxt;
      w        <= (state_nxt == WAIT);
      readnum  <= 3'd0;
      writenum <= 3'd0;
      write_q  <= 1'b0;
      loada_q  <= 1'b0;
      loadb_q  <= 1'b0;
      loadc_q  <= 1'b0;
      loads_q  <= 1'b0;
      asel     <= 1'b0;
      bsel     <= 1'b0;
      vsel     <= 2'b00;
      shift    <= 2'b00;
      ALUop    <= 2'b00;
      case (state_nxt)
        WIMM: begin
          writenum <= rn;
          vsel     <= 2'b10;
          write_q  <= 1'b1;
        end
        GETA: begin
          readnum <= rn;
          loada_q <= 1'b1;
        end
        GETB: begin
          readnum <= rm;
          loadb_q <= 1'b1;
          shift   <= sh;
        end
        ALU: begin
          loadc_q <= 1'b1;
          shift   <= sh;
          ALUop   <= (opcode == 3'b101) ? op : 2'b00;
          asel    <= is_mov_reg | is_mvn;
        end
        WRC: begin
          writenum <= rd;
          vsel     <= 2'b00;
          write_q  <= 1'b1;
        end
        STAT: begin
          loads_q <= 1'b1;
          shift   <= sh;
          ALUop   <= 2'b01;
        end
        default: ;
      endcase
    end
  end

`ifdef DATAPATH_CTRL_ILLEGAL_TRAP_EN
  logic illegal_q;
  always_ff @(posedge clk) begin
    if (reset) illegal_q <= 1'b0;
    else       illegal_q <= (state_nxt == HALT);
  end
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_datapath_ctrl.sv
// Directed self-checking bench for datapath_ctrl; drives and samples on the falling clock edge.
module tb_datapath_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        s;
  logic [15:0] instr;
  logic        w;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write;
  logic        loada;
  logic        loadb;
  logic        loadc;
  logic        loads;
  logic        asel;
  logic        bsel;
  logic [1:0]  vsel;
  logic [1:0]  shift;
  logic [1:0]  ALUop;
  logic [15:0] sximm8;
  logic [15:0] sximm5;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  datapath_ctrl dut (
    .clk(clk), .reset(reset), .s(s), .instr(instr), .w(w),
    .readnum(readnum), .writenum(writenum), .write(write),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .vsel(vsel), .shift(shift), .ALUop(ALUop),
    .sximm8(sximm8), .sximm5(sximm5), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Start one instruction, count busy cycles and record what was seen while busy.
  task automatic run(input logic [15:0] ins, output int busy, output logic wr_seen,
                     output logic asel_seen, output logic [1:0] aluop_c);
    s = 1'b1; instr = ins;
    step();
    s = 1'b0;
    busy = 0; wr_seen = 1'b0; asel_seen = 1'b0; aluop_c = 2'b00;
    while (w !== 1'b1 && busy < 20) begin
      busy++;
      if (write === 1'b1) wr_seen = 1'b1;
      if (asel === 1'b1) asel_seen = 1'b1;
      if (loadc === 1'b1) aluop_c = ALUop;
      step();
    end
  endtask

  int         busy;
  logic       wr_seen;
  logic       asel_seen;
  logic [1:0] aluop_c;

  initial begin
    reset = 1'b1; s = 1'b0; instr = 16'h0000;
    step(); step();
    chk("rst_w", 32'(w), 1);
    chk("rst_write", 32'(write), 0);
    chk("rst_loads", 32'({loada, loadb, loadc, loads}), 0);
    chk("rst_illegal", 32'(illegal), 0);
    chk("rst_sximm8", 32'(sximm8), 0);
    chk("rst_sximm5", 32'(sximm5), 0);

    // s with reset in WAIT: reset wins, nothing latched
    s = 1'b1; instr = 16'hD007;
    step();
    chk("rst_s_w", 32'(w), 1);
    chk("rst_s_sximm8", 32'(sximm8), 0);
    reset = 1'b0; s = 1'b0;
    step();

    // MOV R0,#7
    s = 1'b1; instr = 16'hD007;
    step();
    s = 1'b0;
    chk("movi_dec_w", 32'(w), 0);
    chk("movi_dec_write", 32'(write), 0);
    step();
    chk("movi_wimm_w", 32'(w), 0);
    chk("movi_wimm_writenum", 32'(writenum), 0);
    chk("movi_wimm_vsel", 32'(vsel), 2);
    chk("movi_wimm_write", 32'(write), 1);
    chk("movi_sximm8", 32'(sximm8), 32'h0007);
    step();
    chk("movi_done_w", 32'(w), 1);
    chk("movi_done_write", 32'(write), 0);

    // MOV R1,#-2 issued in the first WAIT cycle
    s = 1'b1; instr = 16'hD1FE;
    step();
    s = 1'b0;
    chk("movn_dec_w", 32'(w), 0);
    step();
    chk("movn_wimm_writenum", 32'(writenum), 1);
    chk("movn_wimm_write", 32'(write), 1);
    chk("movn_sximm8", 32'(sximm8), 32'hFFFE);
    step();
    chk("movn_done_w", 32'(w), 1);

    // ADD R2,R1,R0,LSL#1 with s and instr wiggled while busy
    s = 1'b1; instr = 16'hA148;
    step();
    chk("add_dec_w", 32'(w), 0);
    chk("add_dec_strobes", 32'({loada, loadb, loadc, loads, write}), 0);
    instr = 16'hFFFF;
    step();
    s = 1'b0;
    chk("add_geta_readnum", 32'(readnum), 1);
    chk("add_geta_loada", 32'(loada), 1);
    chk("add_geta_loadb", 32'(loadb), 0);
    step();
    s = 1'b1;
    chk("add_getb_readnum", 32'(readnum), 0);
    chk("add_getb_loadb", 32'(loadb), 1);
    chk("add_getb_shift", 32'(shift), 1);
    chk("add_getb_loada", 32'(loada), 0);
    step();
    chk("add_alu_loadc", 32'(loadc), 1);
    chk("add_alu_aluop", 32'(ALUop), 0);
    chk("add_alu_shift", 32'(shift), 1);
    chk("add_alu_asel", 32'(asel), 0);
    chk("add_alu_w", 32'(w), 0);
    step();
    s = 1'b0;
    chk("add_wrc_writenum", 32'(writenum), 2);
    chk("add_wrc_write", 32'(write), 1);
    chk("add_wrc_vsel", 32'(vsel), 0);
    chk("add_sximm5", 32'(sximm5), 32'h0008);
    chk("add_sximm8", 32'(sximm8), 32'h0048);
    step();
    chk("add_done_w", 32'(w), 1);
    chk("add_done_write", 32'(write), 0);

    // CMP R0,R1
    s = 1'b1; instr = 16'hA801;
    step();
    s = 1'b0;
    chk("cmp_b1_write", 32'(write), 0);
    step();
    chk("cmp_b2_loada", 32'(loada), 1);
    chk("cmp_b2_write", 32'(write), 0);
    step();
    chk("cmp_b3_readnum", 32'(readnum), 1);
    chk("cmp_b3_write", 32'(write), 0);
    step();
    chk("cmp_b4_loads", 32'(loads), 1);
    chk("cmp_b4_aluop", 32'(ALUop), 1);
    chk("cmp_b4_loadc", 32'(loadc), 0);
    chk("cmp_b4_write", 32'(write), 0);
    chk("cmp_b4_w", 32'(w), 0);
    step();
    chk("cmp_done_w", 32'(w), 1);

    // busy-cycle counts
    run(16'hA148, busy, wr_seen, asel_seen, aluop_c);
    chk("add_busy", 32'(busy), 5);
    run(16'hA801, busy, wr_seen, asel_seen, aluop_c);
    chk("cmp_busy", 32'(busy), 4);
    chk("cmp_no_write", 32'(wr_seen), 0);
    run(16'hD007, busy, wr_seen, asel_seen, aluop_c);
    chk("movi_busy", 32'(busy), 2);
    run(16'hC0E1, busy, wr_seen, asel_seen, aluop_c);
    chk("movr_busy", 32'(busy), 4);
    chk("movr_asel", 32'(asel_seen), 1);
    chk("movr_aluop", 32'(aluop_c), 0);
    run(16'hB8E0, busy, wr_seen, asel_seen, aluop_c);
    chk("mvn_busy", 32'(busy), 4);
    chk("mvn_asel", 32'(asel_seen), 1);
    chk("mvn_aluop", 32'(aluop_c), 3);
    run(16'hB000, busy, wr_seen, asel_seen, aluop_c);
    chk("and_busy", 32'(busy), 5);
    chk("and_asel", 32'(asel_seen), 0);
    chk("and_aluop", 32'(aluop_c), 2);
    chk("and_write", 32'(wr_seen), 1);

    // reset asserted in GETB
    s = 1'b1; instr = 16'hA148;
    step();
    s = 1'b0;
    step();
    step();
    reset = 1'b1;
    #1;
    chk("rstb_loadb", 32'(loadb), 0);
    chk("rstb_loadc", 32'(loadc), 0);
    chk("rstb_write", 32'(write), 0);
    step();
    reset = 1'b0;
    #1;
    chk("rstb_w", 32'(w), 1);
    chk("rstb_sximm8", 32'(sximm8), 0);
    step();
    chk("rstb_idle_w", 32'(w), 1);
    chk("rstb_idle_loadc", 32'(loadc), 0);

    // unsupported instruction
`ifdef DATAPATH_CTRL_ILLEGAL_TRAP_EN
    s = 1'b1; instr = 16'hE000;
    step();
    s = 1'b0;
    step();
    chk("ill_illegal", 32'(illegal), 1);
    chk("ill_w", 32'(w), 0);
    step(); step(); step();
    chk("ill_hold_illegal", 32'(illegal), 1);
    chk("ill_hold_w", 32'(w), 0);
    chk("ill_hold_strobes", 32'({loada, loadb, loadc, loads, write}), 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    chk("ill_rst_illegal", 32'(illegal), 0);
    chk("ill_rst_w", 32'(w), 1);
`else
    run(16'hE000, busy, wr_seen, asel_seen, aluop_c);
    chk("ill_busy", 32'(busy), 1);
    chk("ill_no_write", 32'(wr_seen), 0);
    chk("ill_illegal", 32'(illegal), 0);
    chk("ill_done_w", 32'(w), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
